zeroheti_obi_arbiter: RTL and testbench

Parametrised N-to-1 OBI arbiter that merges `NumMgr` OBI manager ports onto one OBI subordinate port. It supports round-robin or fixed-priority arbitration and allows up to `MaxTrans` outstanding transactions, routing in-order responses back to the issuing manager. It replaces the fixed-topology, single-outstanding merge of core masters (debug SBA, instruction fetch, data) in front of shared memories and peripherals. Adding it to a path introduces zero cycles of latency.

---
 rtl/zeroheti_pkg.sv | 14 +
 rtl/zeroheti_id_fifo.sv | 54 +++++
 rtl/zeroheti_obi_arbiter.sv | 113 +++++++++++
 tb/tb_zeroheti_obi_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// Shared types and helpers for the zeroheti interconnect blocks.
package zeroheti_pkg;

  typedef enum logic {
    ArbRoundRobin = 1'b0,
    ArbFixedPrio  = 1'b1
  } arb_mode_e;

  // Index width that stays legal (>= 1 bit) for single-entry structures.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zeroheti_id_fifo.sv
// In-order FIFO of manager indices for granted-but-unanswered transactions.
module zeroheti_id_fifo
  import zeroheti_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = clog2_min1(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  assign full_o     = (count_q == CntW'(Depth));
  assign empty_o    = (count_q == '0);
  assign push_en    = push_i & ~full_o;
  assign pop_en     = pop_i & ~empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/zeroheti_obi_arbiter.sv
// N-to-1 OBI arbiter: round-robin or fixed-priority, up to MaxTrans outstanding,
// in-order responses routed back to the issuing manager with zero added latency.
module zeroheti_obi_arbiter
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumMgr    = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxTrans  = 2,
  parameter arb_mode_e   Mode      = ArbRoundRobin
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumMgr-1:0]                     mgr_req_i,
  output logic [NumMgr-1:0]                     mgr_gnt_o,
  input  logic [NumMgr-1:0][AddrWidth-1:0]      mgr_addr_i,
  input  logic [NumMgr-1:0]                     mgr_we_i,
  input  logic [NumMgr-1:0][DataWidth/8-1:0]    mgr_be_i,
  input  logic [NumMgr-1:0][DataWidth-1:0]      mgr_wdata_i,
  output logic [NumMgr-1:0]                     mgr_rvalid_o,
  output logic [DataWidth-1:0]                  mgr_rdata_o,
  output logic                                  mgr_err_o,
  output logic                                  sbr_req_o,
  input  logic                                  sbr_gnt_i,
  output logic [AddrWidth-1:0]                  sbr_addr_o,
  output logic                                  sbr_we_o,
  output logic [DataWidth/8-1:0]                sbr_be_o,
  output logic [DataWidth-1:0]                  sbr_wdata_o,
  input  logic                                  sbr_rvalid_i,
  input  logic [DataWidth-1:0]                  sbr_rdata_i,
  input  logic                                  sbr_err_i,
  output logic                                  spurious_rsp_o
);

  localparam int unsigned IdxW = $clog2(NumMgr);

  logic [NumMgr-1:0] eligible;
  logic [IdxW-1:0]   sel, sel_q, rr_ptr_q, head, idx;
  logic              lock_q, found, handshake, full, empty, pop;

  // Gating with the asynchronous reset keeps request/grant low while reset is held.
  assign eligible  = mgr_req_i & {NumMgr{~full & ~rst_i}};
  assign sbr_req_o = |eligible;
  assign handshake = sbr_req_o & sbr_gnt_i;
  assign pop       = sbr_rvalid_i & ~empty;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = sel_q;
    end else begin
      for (int i = 0; i < NumMgr; i++) begin
        idx = IdxW'((int'(rr_ptr_q) + i) % NumMgr);
        if (!found && eligible[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mgr_gnt_o         = '0;
    mgr_gnt_o[sel]    = handshake;
    mgr_rvalid_o      = '0;
    mgr_rvalid_o[head] = pop;
  end

  assign sbr_addr_o     = mgr_addr_i[sel];
  assign sbr_we_o       = mgr_we_i[sel];
  assign sbr_be_o       = mgr_be_i[sel];
  assign sbr_wdata_o    = mgr_wdata_i[sel];
  assign mgr_rdata_o    = sbr_rdata_i;
  assign mgr_err_o      = sbr_err_i;
  assign spurious_rsp_o = sbr_rvalid_i & empty & ~rst_i;

  // A pending request freezes the selection so the payload stays stable until granted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q   <= 1'b0;
      sel_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (handshake) begin
        lock_q <= 1'b0;
      end else if (sbr_req_o) begin
        lock_q <= 1'b1;
        sel_q  <= sel;
      end
      if (handshake && Mode == ArbRoundRobin) begin
        rr_ptr_q <= (sel == IdxW'(NumMgr - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  zeroheti_id_fifo #(
    .Depth (MaxTrans),
    .Width (IdxW)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (handshake),
    .push_data_i (sel),
    .pop_i       (sbr_rvalid_i),
    .pop_data_o  (head),
    .full_o      (full),
    .empty_o     (empty)
  );

endmodule

// File: tb/tb_zeroheti_obi_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter share stimulus and
// are compared every cycle against a transaction-level model, plus directed scenarios.
module tb_zeroheti_obi_arbiter;
  import zeroheti_pkg::*;

  localparam int N  = 3;
  localparam int IW = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]              req;
  logic [N-1:0][AW-1:0]      addr;
  logic [N-1:0]              we;
  logic [N-1:0][DW/8-1:0]    be;
  logic [N-1:0][DW-1:0]      wdata;
  logic                      sgnt, srvalid, serr;
  logic [DW-1:0]             srdata;

  logic [N-1:0]   o_gnt [2];
  logic [N-1:0]   o_rvalid [2];
  logic [DW-1:0]  o_rdata [2];
  logic           o_err [2];
  logic           o_req [2];
  logic [AW-1:0]  o_addr [2];
  logic           o_we [2];
  logic [DW/8-1:0] o_be [2];
  logic [DW-1:0]  o_wdata [2];
  logic           o_spur [2];

  zeroheti_obi_arbiter #(
    .NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT), .Mode(ArbRoundRobin)
  ) dut_rr (
    .clk_i(clk), .rst_i(rst),
    .mgr_req_i(req), .mgr_gnt_o(o_gnt[0]), .mgr_addr_i(addr), .mgr_we_i(we),
    .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_rvalid_o(o_rvalid[0]),
    .mgr_rdata_o(o_rdata[0]), .mgr_err_o(o_err[0]),
    .sbr_req_o(o_req[0]), .sbr_gnt_i(sgnt), .sbr_addr_o(o_addr[0]), .sbr_we_o(o_we[0]),
    .sbr_be_o(o_be[0]), .sbr_wdata_o(o_wdata[0]), .sbr_rvalid_i(srvalid),
    .sbr_rdata_i(srdata), .sbr_err_i(serr), .spurious_rsp_o(o_spur[0])
  );

  zeroheti_obi_arbiter #(
    .NumMgr(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT), .Mode(ArbFixedPrio)
  ) dut_fp (
    .clk_i(clk), .rst_i(rst),
    .mgr_req_i(req), .mgr_gnt_o(o_gnt[1]), .mgr_addr_i(addr), .mgr_we_i(we),
    .mgr_be_i(be), .mgr_wdata_i(wdata), .mgr_rvalid_o(o_rvalid[1]),
    .mgr_rdata_o(o_rdata[1]), .mgr_err_o(o_err[1]),
    .sbr_req_o(o_req[1]), .sbr_gnt_i(sgnt), .sbr_addr_o(o_addr[1]), .sbr_we_o(o_we[1]),
    .sbr_be_o(o_be[1]), .sbr_wdata_o(o_wdata[1]), .sbr_rvalid_i(srvalid),
    .sbr_rdata_i(srdata), .sbr_err_i(serr), .spurious_rsp_o(o_spur[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: outstanding issuers as queues, a priority pointer, a lock flag.
  int q_rr[$];
  int q_fp[$];
  int ptr [2];
  bit lk [2];
  int lk_id [2];

  bit           e_any [2];
  int           e_win [2];
  logic [N-1:0] e_gnt [2];
  logic [N-1:0] e_rv [2];
  bit           e_spur [2];

  function automatic int qsize(input bit m);
    return m ? q_fp.size() : q_rr.size();
  endfunction

  function automatic int qhead(input bit m);
    return m ? q_fp[0] : q_rr[0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    q_rr.delete();
    q_fp.delete();
    for (int mi = 0; mi < 2; mi++) begin
      ptr[1'(mi)]   = 0;
      lk[1'(mi)]    = 1'b0;
      lk_id[1'(mi)] = 0;
    end
  endtask

  task automatic model_eval();
    for (int mi = 0; mi < 2; mi++) begin
      bit m;
      bit any;
      int win;
      int cnt;
      m   = 1'(mi);
      cnt = qsize(m);
      any = 1'b0;
      win = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr[m] + k) % N;
        if (req[IW'(i)] && cnt < MT && rst == 1'b0) begin
          any = 1'b1;
          if (win < 0) win = i;
        end
      end
      if (lk[m]) win = lk_id[m];
      else if (win < 0) win = 0;
      e_any[m]  = any;
      e_win[m]  = win;
      e_gnt[m]  = (any && sgnt) ? N'(1) << win : '0;
      e_rv[m]   = (srvalid && cnt > 0 && rst == 1'b0) ? N'(1) << qhead(m) : '0;
      e_spur[m] = srvalid && cnt == 0 && rst == 1'b0;
    end
  endtask

  task automatic model_update();
    for (int mi = 0; mi < 2; mi++) begin
      bit m;
      m = 1'(mi);
      if (srvalid && qsize(m) > 0) begin
        if (m) void'(q_fp.pop_front()); else void'(q_rr.pop_front());
      end
      if (e_any[m] && sgnt) begin
        if (m) q_fp.push_back(e_win[m]); else q_rr.push_back(e_win[m]);
        if (!m) ptr[m] = (e_win[m] + 1) % N;
        lk[m] = 1'b0;
      end else if (e_any[m]) begin
        lk[m]    = 1'b1;
        lk_id[m] = e_win[m];
      end
    end
  endtask

  task automatic compare_all();
    for (int mi = 0; mi < 2; mi++) begin
      bit m;
      string pfx;
      logic [IW-1:0] w;
      m   = 1'(mi);
      pfx = m ? "fp" : "rr";
      w   = IW'(e_win[m]);
      check({pfx, "_req"},    64'(o_req[m]),    64'(e_any[m]));
      check({pfx, "_gnt"},    64'(o_gnt[m]),    64'(e_gnt[m]));
      check({pfx, "_rvalid"}, 64'(o_rvalid[m]), 64'(e_rv[m]));
      check({pfx, "_spur"},   64'(o_spur[m]),   64'(e_spur[m]));
      check({pfx, "_rdata"},  64'(o_rdata[m]),  64'(srdata));
      check({pfx, "_err"},    64'(o_err[m]),    64'(serr));
      check({pfx, "_addr"},   64'(o_addr[m]),   64'(addr[w]));
      check({pfx, "_we"},     64'(o_we[m]),     64'(we[w]));
      check({pfx, "_be"},     64'(o_be[m]),     64'(be[w]));
      check({pfx, "_wdata"},  64'(o_wdata[m]),  64'(wdata[w]));
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    #1;
    model_eval();
    compare_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    #1;
    model_eval();
    compare_all();
    for (int mi = 0; mi < 2; mi++) begin
      check("rst_req",    64'(o_req[1'(mi)]),    64'(0));
      check("rst_gnt",    64'(o_gnt[1'(mi)]),    64'(0));
      check("rst_rvalid", 64'(o_rvalid[1'(mi)]), 64'(0));
      check("rst_spur",   64'(o_spur[1'(mi)]),   64'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle();
    req     = '0;
    sgnt    = 1'b0;
    srvalid = 1'b0;
    serr    = 1'b0;
    srdata  = $urandom();
    for (int i = 0; i < N; i++) begin
      addr[IW'(i)]  = $urandom();
      we[IW'(i)]    = 1'($urandom());
      be[IW'(i)]    = 4'($urandom());
      wdata[IW'(i)] = $urandom();
    end
  endtask

  task automatic drain();
    req  = '0;
    sgnt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      srvalid = (qsize(1'b0) > 0) || (qsize(1'b1) > 0);
      cycle();
    end
    srvalid = 1'b0;
  endtask

  initial begin
    int exp_seq[$];
    logic [N-1:0] last_gnt;
    exp_seq = '{0, 1, 2, 0, 1, 2};

    // Reset state, including requests held high during reset.
    idle();
    req = '1;
    apply_reset();
    req = '0;

    // Round-robin rotation with single-cycle responses.
    req  = '1;
    sgnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      srvalid = qsize(1'b0) > 0;
      srdata  = $urandom();
      #1;
      check("rr_rotate", 64'(o_gnt[0]), 64'(N'(1) << exp_seq[k]));
      if (k > 0) check("rr_rsp_next_cycle", 64'(o_rvalid[0]), 64'(N'(1) << exp_seq[k - 1]));
      cycle();
    end
    drain();

    // Lock: manager 1 waits without grant, manager 0 joins later.
    apply_reset();
    req     = 3'b010;
    addr[1] = 32'h100;
    addr[0] = 32'h200;
    sgnt    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) req[0] = 1'b1;
      #1;
      check("lock_addr_rr", 64'(o_addr[0]), 64'h100);
      check("lock_addr_fp", 64'(o_addr[1]), 64'h100);
      cycle();
    end
    sgnt = 1'b1;
    #1;
    check("lock_gnt_rr", 64'(o_gnt[0]), 64'b010);
    check("lock_gnt_fp", 64'(o_gnt[1]), 64'b010);
    cycle();
    req[1] = 1'b0;
    #1;
    check("after_lock_rr", 64'(o_gnt[0]), 64'b001);
    check("after_lock_fp", 64'(o_gnt[1]), 64'b001);
    check("after_lock_addr", 64'(o_addr[0]), 64'h200);
    cycle();
    drain();

    // Full FIFO: two grants, no responses, then in-order responses.
    apply_reset();
    req  = 3'b011;
    sgnt = 1'b1;
    cycle();
    cycle();
    #1;
    check("full_req_rr", 64'(o_req[0]), 64'(0));
    check("full_req_fp", 64'(o_req[1]), 64'(0));
    check("full_gnt_rr", 64'(o_gnt[0]), 64'(0));
    cycle();
    srvalid = 1'b1;
    #1;
    check("full_rsp1_rr", 64'(o_rvalid[0]), 64'b001);
    check("full_pop_req", 64'(o_req[0]), 64'(0));
    cycle();
    #1;
    check("full_rsp2_rr", 64'(o_rvalid[0]), 64'b010);
    check("full_rsp2_fp", 64'(o_rvalid[1]), 64'b001);
    check("full_regrant_rr", 64'(o_gnt[0]), 64'b001);
    cycle();
    drain();

    // Fixed priority: lowest index wins until it drops its request.
    apply_reset();
    req  = 3'b101;
    sgnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      srvalid = qsize(1'b1) > 0;
      #1;
      check("fp_prio", 64'(o_gnt[1]), 64'b001);
      cycle();
    end
    req     = 3'b100;
    srvalid = qsize(1'b1) > 0;
    #1;
    check("fp_low_prio", 64'(o_gnt[1]), 64'b100);
    cycle();
    drain();

    // Spurious response with nothing outstanding.
    idle();
    srvalid = 1'b1;
    #1;
    check("spur_rr", 64'(o_spur[0]), 64'(1));
    check("spur_fp", 64'(o_spur[1]), 64'(1));
    check("spur_no_rvalid", 64'(o_rvalid[0]), 64'(0));
    cycle();
    srvalid = 1'b0;
    #1;
    check("spur_pulse_end", 64'(o_spur[0]), 64'(0));
    cycle();

    // Reset with two transactions outstanding.
    req  = 3'b011;
    sgnt = 1'b1;
    cycle();
    cycle();
    apply_reset();
    req     = '0;
    srvalid = 1'b1;
    #1;
    check("post_rst_spur", 64'(o_spur[0]), 64'(1));
    check("post_rst_rvalid", 64'(o_rvalid[0]), 64'(0));
    cycle();
    srvalid = 1'b0;
    req     = '1;
    #1;
    check("post_rst_rr_start", 64'(o_gnt[0]), 64'b001);
    cycle();
    drain();

    // Randomized traffic; a request is held until the round-robin arbiter grants it.
    last_gnt = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req[IW'(i)] && !last_gnt[IW'(i)])) begin
          req[IW'(i)]   = $urandom_range(0, 99) < 60;
          addr[IW'(i)]  = $urandom();
          we[IW'(i)]    = 1'($urandom());
          be[IW'(i)]    = 4'($urandom());
          wdata[IW'(i)] = $urandom();
        end
      end
      sgnt    = $urandom_range(0, 99) < 70;
      srvalid = (qsize(1'b0) > 0) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 5);
      serr    = 1'($urandom());
      srdata  = $urandom();
      cycle();
      last_gnt = e_gnt[0];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
